// File: rtl/fix_decimate_acc_pkg.sv
// fix_decimate_acc_pkg: shared widths and out-of-range mode for the decimator.
// The out-of-range mode is chosen at build time by FIX_DECIMATE_SAT_EN (clamp when defined, wrap otherwise).
package fix_decimate_acc_pkg;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } ovf_mode_e;

`ifdef FIX_DECIMATE_SAT_EN
    localparam ovf_mode_e OVF_MODE = MODE_SAT;
`else
    localparam ovf_mode_e OVF_MODE = MODE_WRAP;
`endif

    function automatic int fix_w(input int n_int, input int n_mant);
        return n_int + n_mant + 1;
    endfunction

    // Room for OSR full-scale samples, so the frame sum can never overflow.
    function automatic int acc_w(input int n_int, input int n_mant, input int osr);
        return fix_w(n_int, n_mant) + $clog2(osr);
    endfunction

endpackage

// File: rtl/fix_round_sat.sv
// fix_round_sat: rescale a wide signed sum to the output format, rounding half up and clamping or wrapping.
module fix_round_sat
    import fix_decimate_acc_pkg::*;
#(
    parameter int        AW         = 35,
    parameter int        n_mant_in  = 23,
    parameter int        n_int_out  = 8,
    parameter int        n_mant_out = 23,
    parameter ovf_mode_e MODE       = OVF_MODE
) (
    input  logic [AW-1:0]                            sum_i,
    output logic [fix_w(n_int_out, n_mant_out)-1:0] res_o,
    output logic                                     ovf_o
);

    localparam int OW = fix_w(n_int_out, n_mant_out);
    localparam int LS = n_mant_out > n_mant_in ? n_mant_out - n_mant_in : 0;
    localparam int RS = n_mant_in > n_mant_out ? n_mant_in - n_mant_out : 0;
    // One spare bit absorbs the rounding carry; at least OW+1 bits so the range test has a guard bit.
    localparam int EW = (AW + LS + 1 > OW + 1) ? AW + LS + 1 : OW + 1;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] r;
    logic [EW-OW:0]       hi;

    assign ext = EW'($signed(sum_i));

    if (RS > 0) begin : g_rnd
        localparam logic signed [EW-1:0] HALF = EW'(64'sd1 << (RS - 1));
        assign r = (ext + HALF) >>> RS;
    end else begin : g_shl
        assign r = ext <<< LS;
    end

    // In range only when every bit above the output sign bit repeats it.
    assign hi    = r[EW-1:OW-1];
    assign ovf_o = !((&hi) || !(|hi));
    assign res_o = (ovf_o && MODE == MODE_SAT) ? {r[EW-1], {(OW-1){~r[EW-1]}}} : r[OW-1:0];

endmodule

// File: rtl/fix_decimate_acc.sv
// fix_decimate_acc: sums OSR signed samples per frame and presents the rescaled result on valid/ready.
// Build option FIX_DECIMATE_SAT_EN: clamp out-of-range results instead of wrapping them.
module fix_decimate_acc
    import fix_decimate_acc_pkg::*;
#(
    parameter int n_int_in   = 8,
    parameter int n_mant_in  = 23,
    parameter int n_int_out  = 8,
    parameter int n_mant_out = 23,
    parameter int OSR        = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [fix_w(n_int_in, n_mant_in)-1:0]   in,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic                                     clear,
    output logic [fix_w(n_int_out, n_mant_out)-1:0] out,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     ovf
);

    localparam int AW = acc_w(n_int_in, n_mant_in, OSR);
    localparam int OW = fix_w(n_int_out, n_mant_out);
    localparam int CW = $clog2(OSR);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d, in_ext, sum;
    logic [OW-1:0]        out_q, out_d, res;
    logic                 out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic                 res_ovf, last, first, accept, done;

    assign in_ext = AW'($signed(in));
    assign last   = cnt_q == CW'(OSR - 1);
    // Only the frame-completing sample must wait for a free holding register.
    assign in_ready = !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    // A clear restarts the frame, so a sample arriving with it is the first of the new frame.
    assign first = clear || cnt_q == '0;
    assign done  = accept && !clear && last;
    assign sum   = first ? in_ext : acc_q + in_ext;

    fix_round_sat #(
        .AW        (AW),
        .n_mant_in (n_mant_in),
        .n_int_out (n_int_out),
        .n_mant_out(n_mant_out)
    ) u_round (
        .sum_i(sum),
        .res_o(res),
        .ovf_o(res_ovf)
    );

    // Next-state for frame counter, accumulator, holding register and sticky overflow.
    always_comb begin
        cnt_d       = accept ? (first ? CW'(1) : last ? '0 : cnt_q + CW'(1)) : clear ? '0 : cnt_q;
        acc_d       = accept ? sum : acc_q;
        out_d       = done ? res : out_q;
        out_valid_d = done || (out_valid_q && !out_ready);
        ovf_d       = ovf_q || (done && res_ovf);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fix_decimate_acc.sv
// tb_fix_decimate_acc: directed plan plus random traffic checked against a frame-level reference model.
module tb_fix_decimate_acc;

    localparam int NII  = 3;
    localparam int NMI  = 4;
    localparam int NIO  = 4;
    localparam int NMO  = 2;
    localparam int OSR  = 4;
    localparam int IW   = NII + NMI + 1;
    localparam int OW   = NIO + NMO + 1;
    localparam int RS   = NMI - NMO;
    localparam int OMAX = (1 << (OW - 1)) - 1;
    localparam int OMIN = -(1 << (OW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          clear = 1'b0;
    logic [OW-1:0] out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    int frame[$];
    int exp_out = 0;
    bit exp_valid = 1'b0;
    bit exp_ovf = 1'b0;
    bit m_rdy, m_done, m_o;
    int m_sum;

    fix_decimate_acc #(
        .n_int_in  (NII),
        .n_mant_in (NMI),
        .n_int_out (NIO),
        .n_mant_out(NMO),
        .OSR       (OSR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round half up to NMO fraction bits, then clamp or wrap into OW bits.
    function automatic int conv(input int s, output bit o);
        int r;
`ifndef FIX_DECIMATE_SAT_EN
        int m;
`endif
        r = (s + (1 << (RS - 1))) >>> RS;
        o = r > OMAX || r < OMIN;
`ifdef FIX_DECIMATE_SAT_EN
        return r > OMAX ? OMAX : r < OMIN ? OMIN : r;
`else
        m = ((r % (1 << OW)) + (1 << OW)) % (1 << OW);
        return m > OMAX ? m - (1 << OW) : m;
`endif
    endfunction

    // Reference model: a frame is a list of accepted samples; a full list becomes one result.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame.delete();
            exp_valid = 1'b0;
            exp_out   = 0;
            exp_ovf   = 1'b0;
        end else begin
            m_rdy  = !(frame.size() == OSR - 1 && exp_valid && !out_ready);
            m_done = 1'b0;
            if (clear) frame.delete();
            if (in_valid && m_rdy) begin
                frame.push_back(int'($signed(in)));
                if (frame.size() == OSR) begin
                    m_sum = 0;
                    foreach (frame[k]) m_sum += frame[k];
                    exp_out = conv(m_sum, m_o);
                    exp_ovf = exp_ovf || m_o;
                    m_done  = 1'b1;
                    frame.delete();
                end
            end
            if (m_done) exp_valid = 1'b1;
            else if (out_ready) exp_valid = 1'b0;
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("in_ready", int'(in_ready), int'(!(frame.size() == OSR - 1 && exp_valid && !out_ready)));
        chk("ovf", int'(ovf), int'(exp_ovf));
        if (exp_valid) chk("out", int'($signed(out)), exp_out);
    end

    task automatic step(input logic v, input int d, input logic c, input logic r);
        in_valid  = v;
        in        = IW'(d);
        clear     = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d, input int exp, input string name);
        step(1, a, 0, 1);
        step(1, b, 0, 1);
        step(1, c, 0, 1);
        step(1, d, 0, 1);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_out"}, int'($signed(out)), exp);
        chk({name, "_model"}, exp_out, exp);
        step(0, 0, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_out", int'(out), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 0, 1);

        // Full-scale ones sum to 4.0; result visible for exactly one cycle.
        frame4(16, 16, 16, 16, 16, "s1");
        chk("s1_pulse_end", int'(out_valid), 0);

        frame4(2, 0, 0, 0, 1, "s2_half_up");
        frame4(-2, 0, 0, 0, 0, "s2_neg_half");
        frame4(1, 0, 0, 0, 0, "s2_quarter");

        // Stalled output: only the 8th, frame-completing sample waits.
        for (int i = 0; i < 7; i++) step(1, 16, 0, 0);
        chk("s4_held_valid", int'(out_valid), 1);
        in_valid  = 1'b1;
        in        = IW'(16);
        out_ready = 1'b0;
        #1;
        chk("s4_stall", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("s4_hold_out", int'($signed(out)), 16);
        out_ready = 1'b1;
        #1;
        chk("s4_release", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("s4_new_valid", int'(out_valid), 1);
        chk("s4_new_out", int'($signed(out)), 16);
        step(0, 0, 0, 1);
        chk("s4_drained", int'(out_valid), 0);

        // Clear with the 3rd sample restarts the frame at that sample.
        step(1, 16, 0, 1);
        step(1, 16, 0, 1);
        step(1, 16, 1, 1);
        step(1, 16, 0, 1);
        step(1, 16, 0, 1);
        chk("s6_no_early", int'(out_valid), 0);
        step(1, 16, 0, 1);
        chk("s6_valid", int'(out_valid), 1);
        chk("s6_out", int'($signed(out)), 16);
        step(0, 0, 0, 1);

        // Reset mid-frame discards the partial sum.
        step(1, 16, 0, 1);
        step(1, 16, 0, 1);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("s5_valid_low", int'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        frame4(4, 4, 4, 4, 4, "s5");
        chk("s5_ovf_clear", int'(ovf), 0);

`ifdef FIX_DECIMATE_SAT_EN
        frame4(127, 127, 127, 127, 63, "s3_sat");
`else
        frame4(127, 127, 127, 127, -1, "s3_wrap");
`endif
        chk("s3_ovf", int'(ovf), 1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst = 1'b0;
            if (i == 1501) rst = 1'b1;
            step($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
